// File: rtl/bsg_counter_set_down_max_val_p65_init_val_p0.sv
// rtl/bsg_counter_set_down_max_val_p65_init_val_p0.sv - loadable saturating down-counter
// Load clamps to max_val_p, decrement stops at zero; expiry pulse and sticky misuse error.
module bsg_counter_set_down_max_val_p65_init_val_p0 #(
  parameter int max_val_p  = 65,
  parameter int init_val_p = 0,
  localparam int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                set_i,
  input  logic [width_lp-1:0] val_i,
  input  logic                down_i,
  input  logic                clear_err_i,
  output logic [width_lp-1:0] count_o,
  output logic                zero_o,
  output logic                expire_o,
  output logic                err_o
);

  localparam logic [width_lp-1:0] max_lp  = width_lp'(max_val_p);
  localparam logic [width_lp-1:0] init_lp = width_lp'(init_val_p);

  logic [width_lp-1:0] count_r, count_n;
  logic                expire_r, expire_n;
  logic                err_r, err_n, err_new;

  always_comb begin
    count_n  = count_r;
    expire_n = 1'b0;
    err_new  = 1'b0;
    if (set_i) begin
      // Load has priority; down_i is dropped this cycle and never expires.
      if (val_i > max_lp) begin
        count_n = max_lp;
        err_new = 1'b1;
      end else begin
        count_n = val_i;
      end
    end else if (down_i) begin
      if (count_r != '0) begin
        count_n  = count_r - width_lp'(1);
        expire_n = (count_r == width_lp'(1));
      end else begin
        err_new = 1'b1;
      end
    end
    // A new error beats a simultaneous clear.
    err_n = (err_r & ~clear_err_i) | err_new;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r  <= init_lp;
      expire_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      count_r  <= count_n;
      expire_r <= expire_n;
      err_r    <= err_n;
    end
  end

  assign count_o  = count_r;
  assign zero_o   = (count_r == '0);
  assign expire_o = expire_r;
  assign err_o    = err_r;

endmodule

// File: doc/bsg_counter_set_down_max_val_p65_init_val_p0.md
# bsg_counter_set_down_max_val_p65_init_val_p0

Loadable down-counter that drains the 0..65 range that `bsg_counter_clear_up_max_val_p65_init_val_p0` fills. A producer loads a count, such as a credit or word total, and the consumer retires it one unit per `down_i`. The block flags expiry on the decrement that reaches zero, flags misuse (underflow or over-range load) with a sticky error, and is sized so its count bus connects directly to the up-counter's `count_o`.

## Interface
- `max_val_p`, default 65: maximum representable count; loads above it saturate.
- `init_val_p`, default 0: count value after reset.
- `width_lp`, derived: `$clog2(max_val_p+1)` = 7; not overridable.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `reset_i`  in  1  asynchronous, active-high reset; asserts immediately, deasserts synchronously to `clk_i` upstream.
- `set_i`  in  1  load `val_i` into the count this cycle.
- `val_i`  in  7  load value; sampled only when `set_i`=1.
- `down_i`  in  1  decrement request.
- `clear_err_i`  in  1  clears sticky `err_o`.
- `count_o`  out  7  current count (registered).
- `zero_o`  out  1  `count_o`==0 (decode of the count register; no extra latency).
- `expire_o`  out  1  one-cycle pulse: count reached 0 by decrement.
- `err_o`  out  1  sticky: underflow attempted or over-range load.

## Operation
- Reset (async, active-high): `count_o`=`init_val_p` (0), `zero_o`=1, `expire_o`=0, `err_o`=0. Reset asserted mid-operation overrides everything in the same instant and holds while high.
- Next-count priority, highest first:
  1. `set_i`=1: count <= min(`val_i`, `max_val_p`); `down_i` is ignored this cycle. If `val_i` > 65, the count loads 65 and `err_o` sets.
  2. `down_i`=1 and count>0: count <= count-1.
  3. `down_i`=1 and count==0: count stays 0 (no wrap to 127), `err_o` sets.
  4. Otherwise: hold.
- `expire_o` next value is 1 only when case 2 applies with count==1; otherwise 0. A load of 0 never pulses `expire_o`. A repeated `down_i` at 0 never pulses it.
- `err_o` next value = (`err_o` & ~`clear_err_i`) | new_error. When `clear_err_i` and a new error occur together, the error wins and `err_o` stays 1.
- Arithmetic: 7-bit unsigned. The comparison against `max_val_p` uses the full `val_i` width. The decrement never goes below 0.

## Timing
- All outputs are registered (`zero_o` is a pure decode of the `count_o` register). There are no combinational paths from any input to any output.
- Latency:
  - `set_i` or `down_i` in cycle N is visible on `count_o`/`zero_o` in N+1.
  - `expire_o` is high in N+1, the same cycle `count_o` first reads 0, for exactly one cycle.
  - An error in N shows `err_o`=1 in N+1. `clear_err_i` in N shows `err_o`=0 in N+1 if there is no new error.
- Back-to-back `down_i` decrements every cycle. Throughput is one operation per cycle.
- `set_i` and `down_i` in the same cycle: the load wins. The count equals the clamped `val_i` and is not decremented. `expire_o`=0 even if the old count was 1.

## Test plan
- Reset: assert `reset_i` asynchronously between clock edges -> `count_o`=0, `zero_o`=1, `expire_o`=0, `err_o`=0 immediately, without waiting for a clock edge.
- Load then drain: `set_i`, `val_i`=3, then `down_i` for 3 cycles.
  - `count_o` sequence is 3, 2, 1, 0.
  - `expire_o`=1 only in the cycle `count_o` first reads 0.
  - `zero_o`=1 from that cycle.
  - `err_o`=0 throughout.
- Underflow: at count 0, `down_i`=1 for 2 cycles -> `count_o` stays 0, `err_o`=1 next cycle and stays 1, `expire_o` stays 0. Then `clear_err_i` alone -> `err_o`=0 next cycle.
- Over-range load: `set_i`, `val_i`=100 -> `count_o`=65, `err_o`=1. Then `set_i`, `val_i`=65 -> `count_o`=65, no new error.
- Simultaneous events:
  - Count=1, `set_i`=1 with `val_i`=10 and `down_i`=1 -> `count_o`=10, `expire_o`=0.
  - Count=0, `down_i`=1 and `clear_err_i`=1 with `err_o`=1 -> `err_o` stays 1.
- Reset mid-drain: load 40, decrement 5 times, assert `reset_i` -> `count_o`=0, `err_o`=0. After reset deasserts, `down_i` -> `err_o`=1 (underflow from the reset value).
